recip_engine: RTL and testbench
===============================

Name: recip_engine

Overview:
- Hardware responder for the Start/Ack program-launch handshake. It performs the program-1 job, 16-bit reciprocal x -> floor(2^15/x), as a dedicated sequencer.
- Reads the big-endian divisor from data memory bytes OPND_ADDR/OPND_ADDR+1 and runs a bit-serial restoring divide.
- Writes the 16-bit result big-endian to RES_ADDR/RES_ADDR+1, then raises Ack.
- Sits beside the data memory as an alternate bus master to the CPU core; uses the same byte-wide memory port.

Parameters:
OPND_ADDR, 8, byte address of divisor high byte (low byte at +1)
RES_ADDR, 10, byte address of result high byte (low byte at +1)
ROUND, 0, 0 = truncate; 1 = half-LSB upward rounding
ADDR_W, 8, data memory address width

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high reset
Start  in  1  level; high holds engine idle / re-arms; run launches when low
Ack  out  1  program run complete; held until Start goes high
Busy  out  1  high in any state other than IDLE and DONE
DataAddress  out  ADDR_W  memory byte address
ReadMem  out  1  read strobe; memory read is combinational
WriteMem  out  1  write strobe; memory writes DataIn at rising Clk
DataIn  out  8  write data to memory
DataOut  in  8  read data from memory

Behaviour:
- Reset (async, immediate): state=IDLE; Ack=0, Busy=0, ReadMem=0, WriteMem=0, DataAddress=0, DataIn=0; divisor, remainder, quotient and counter regs cleared.
- States and transitions:
  - IDLE: if Start==0 at an edge -> RD_HI; otherwise stay.
  - RD_HI: DataAddress=OPND_ADDR, ReadMem=1; at edge latch DataOut into div[15:8] -> RD_LO.
  - RD_LO: DataAddress=OPND_ADDR+1, ReadMem=1; latch div[7:0] -> CHECK.
  - CHECK: if div==0, result=16'hFFFF -> WR_HI. Else R=0, Q=0, cnt=0 -> DIV.
  - DIV: 17 cycles, one quotient bit per cycle, MSB first, numerator = 2^16 (bit 16 = 1, others 0).
    - Each cycle: T={R[15:0], nbit}. If T>=div then R=T-div, qbit=1; else R=T, qbit=0. Q={Q[15:0], qbit}.
    - R and T are 17 bits. After cnt==16 -> WR_HI.
  - Result (registered on leaving DIV): ROUND=0 gives Q[16:1]; ROUND=1 gives Q[16:1]+Q[0]. No overflow is possible because Q <= 65536.
  - WR_HI: DataAddress=RES_ADDR, WriteMem=1, DataIn=result[15:8] -> WR_LO.
  - WR_LO: DataAddress=RES_ADDR+1, WriteMem=1, DataIn=result[7:0] -> DONE.
  - DONE: Ack=1, Busy=0. If Start==1 at an edge -> IDLE (Ack falls after that edge); otherwise stay.
- Strobes:
  - Strobes are decoded from state and are mutually exclusive.
  - ReadMem and WriteMem are never high in IDLE, CHECK, DIV or DONE.
- Latency, counted from the launch edge (IDLE->RD_HI):
  - Nonzero divisor: Ack high after 22 edges.
  - Zero divisor: Ack high after 5 edges.
- Start rising during RD_HI..WR_LO is ignored; the run completes.
- Start held high across reset release: engine stays in IDLE. The bench pattern (Start pulse during Reset, Start low before Reset falls) launches on the first edge after Reset falls.
- Reset mid-run: immediate abort, no further writes. A partially written result (high byte only) is permitted.
- Divisor >= 0x8001 gives result 0 (ROUND=0) or 1 (ROUND=1). Divisor 1 gives 0x8000 for both settings.

Test Plan:
- Divisor 36 (mem[8]=00, mem[9]=24), ROUND=0, Reset/Start sequence as in the program-1 bench -> mem[10]=03, mem[11]=8E; Ack rises 22 edges after launch; Busy high for the intervening edges.
- Divisor 4 -> 0x2000. Divisor 1 -> 0x8000. Divisor 0xFFFF -> 0x0000.
- Divisor 3 -> 0x2AAA with ROUND=0; 0x2AAB with ROUND=1. Divisor 0xFFFF with ROUND=1 -> 0x0001.
- Divisor 0 -> mem[10]=FF, mem[11]=FF; Ack rises 5 edges after launch; WriteMem high exactly 2 cycles, at addresses 10 then 11.
- Assert Reset during DIV (edge 10 after launch) -> Ack=0 and WriteMem=0 immediately; mem[10..11] unchanged. Rerun with divisor 36 -> 0x038E.
- In DONE, raise Start for 1 cycle -> Ack low next edge, state IDLE. Drop Start -> second run launches and rewrites the same result. Toggling Start mid-run changes neither latency nor result.

Source files
------------

// File: rtl/recip_engine.sv
// rtl/recip_engine.sv - Start/Ack sequencer computing floor(2^15/x) via bit-serial restoring divide
// Reads a big-endian divisor from data memory and writes the big-endian reciprocal back.
module recip_engine #(
  parameter int OPND_ADDR = 8,
  parameter int RES_ADDR  = 10,
  parameter bit ROUND     = 1'b0,
  parameter int ADDR_W    = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ack,
  output logic              Busy,
  output logic [ADDR_W-1:0] DataAddress,
  output logic              ReadMem,
  output logic              WriteMem,
  output logic [7:0]        DataIn,
  input  logic [7:0]        DataOut
);

  localparam logic [ADDR_W-1:0] OPND_HI = ADDR_W'(OPND_ADDR);
  localparam logic [ADDR_W-1:0] OPND_LO = ADDR_W'(OPND_ADDR + 1);
  localparam logic [ADDR_W-1:0] RES_HI  = ADDR_W'(RES_ADDR);
  localparam logic [ADDR_W-1:0] RES_LO  = ADDR_W'(RES_ADDR + 1);

  typedef enum logic [2:0] {
    IDLE, RD_HI, RD_LO, CHECK, DIV, WR_HI, WR_LO, DONE
  } state_t;

  state_t      state;
  logic [15:0] divisor;
  logic [15:0] rem;
  logic [15:0] quo;
  logic [4:0]  cnt;
  logic [7:0]  res_lo;

  logic [16:0] trial;
  logic        fits;
  logic [15:0] rem_next;
  logic [16:0] quo_next;
  logic [15:0] rounded;

  // The remainder never reaches the divisor, so 16 bits hold it; only the
  // shifted trial value needs the 17th bit. The numerator 2^16 feeds a single
  // one-bit on the first step.
  always_comb begin
    trial    = {rem, (cnt == 5'd0)};
    fits     = (trial >= {1'b0, divisor});
    rem_next = fits ? 16'(trial - {1'b0, divisor}) : trial[15:0];
    quo_next = {quo, fits};
    rounded  = quo_next[16:1] + {15'b0, ROUND & quo_next[0]};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      Ack         <= 1'b0;
      Busy        <= 1'b0;
      ReadMem     <= 1'b0;
      WriteMem    <= 1'b0;
      DataAddress <= '0;
      DataIn      <= 8'h00;
      divisor     <= 16'h0000;
      rem         <= 16'h0000;
      quo         <= 16'h0000;
      cnt         <= 5'd0;
      res_lo      <= 8'h00;
    end else begin
      ReadMem  <= 1'b0;
      WriteMem <= 1'b0;
      case (state)
        IDLE: begin
          if (!Start) begin
            state       <= RD_HI;
            Busy        <= 1'b1;
            DataAddress <= OPND_HI;
            ReadMem     <= 1'b1;
          end
        end
        RD_HI: begin
          divisor[15:8] <= DataOut;
          state         <= RD_LO;
          DataAddress   <= OPND_LO;
          ReadMem       <= 1'b1;
        end
        RD_LO: begin
          divisor[7:0] <= DataOut;
          state        <= CHECK;
        end
        CHECK: begin
          if (divisor == 16'h0000) begin
            res_lo      <= 8'hFF;
            DataIn      <= 8'hFF;
            DataAddress <= RES_HI;
            WriteMem    <= 1'b1;
            state       <= WR_HI;
          end else begin
            rem   <= 16'h0000;
            quo   <= 16'h0000;
            cnt   <= 5'd0;
            state <= DIV;
          end
        end
        DIV: begin
          rem <= rem_next;
          quo <= quo_next[15:0];
          cnt <= cnt + 5'd1;
          if (cnt == 5'd16) begin
            res_lo      <= rounded[7:0];
            DataIn      <= rounded[15:8];
            DataAddress <= RES_HI;
            WriteMem    <= 1'b1;
            state       <= WR_HI;
          end
        end
        WR_HI: begin
          DataIn      <= res_lo;
          DataAddress <= RES_LO;
          WriteMem    <= 1'b1;
          state       <= WR_LO;
        end
        WR_LO: begin
          Busy  <= 1'b0;
          Ack   <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (Start) begin
            Ack   <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          Busy  <= 1'b0;
          Ack   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recip_engine.sv
// tb/tb_recip_engine.sv - self-checking bench for recip_engine, truncating and rounding instances
module tb_recip_engine;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b1;

  logic       Ack0, Busy0, ReadMem0, WriteMem0;
  logic [7:0] DataAddress0, DataIn0, DataOut0;
  logic       Ack1, Busy1, ReadMem1, WriteMem1;
  logic [7:0] DataAddress1, DataIn1, DataOut1;

  logic [7:0] mem0 [0:255];
  logic [7:0] mem1 [0:255];

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_run = 1'b0;
  bit          m_ack = 1'b0;
  int          m_k = 0;
  int          m_lat = 0;
  int          m_div = 0;
  logic [15:0] m_res0 = 16'h0;
  logic [15:0] m_res1 = 16'h0;

  recip_engine #(.OPND_ADDR(8), .RES_ADDR(10), .ROUND(1'b0), .ADDR_W(8)) dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack0), .Busy(Busy0),
    .DataAddress(DataAddress0), .ReadMem(ReadMem0), .WriteMem(WriteMem0),
    .DataIn(DataIn0), .DataOut(DataOut0)
  );

  recip_engine #(.OPND_ADDR(8), .RES_ADDR(10), .ROUND(1'b1), .ADDR_W(8)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack1), .Busy(Busy1),
    .DataAddress(DataAddress1), .ReadMem(ReadMem1), .WriteMem(WriteMem1),
    .DataIn(DataIn1), .DataOut(DataOut1)
  );

  always #5 Clk = ~Clk;

  assign DataOut0 = mem0[DataAddress0];
  assign DataOut1 = mem1[DataAddress1];

  always @(posedge Clk) begin
    if (WriteMem0) mem0[DataAddress0] = DataIn0;
    if (WriteMem1) mem1[DataAddress1] = DataIn1;
  end

  // Reciprocal of 2^15 by plain integer arithmetic; rounding adds half an LSB.
  function automatic logic [15:0] recip(input int x, input bit rnd);
    if (x == 0) return 16'hFFFF;
    if (!rnd) return 16'(32768 / x);
    return 16'((65536 + x) / (2 * x));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run timeline: launch edge, two read cycles, then either 17 divide steps or
  // an immediate write, two write cycles, then Ack until Start returns high.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_run = 1'b0;
      m_ack = 1'b0;
      m_k   = 0;
    end else if (m_run) begin
      m_k++;
      if (m_k == m_lat) begin
        m_run = 1'b0;
        m_ack = 1'b1;
      end
    end else if (m_ack) begin
      if (Start) m_ack = 1'b0;
    end else if (!Start) begin
      m_run  = 1'b1;
      m_k    = 0;
      m_div  = {16'h0, mem0[8], mem0[9]};
      m_lat  = (m_div == 0) ? 5 : 22;
      m_res0 = recip(m_div, 1'b0);
      m_res1 = recip(m_div, 1'b1);
    end
  end

  initial begin
    @(posedge Clk);
    forever begin
      @(negedge Clk);
      if (Reset) begin
        check("rst_ack0", 32'(Ack0), 32'd0);
        check("rst_busy0", 32'(Busy0), 32'd0);
        check("rst_rd0", 32'(ReadMem0), 32'd0);
        check("rst_wr0", 32'(WriteMem0), 32'd0);
        check("rst_addr0", 32'(DataAddress0), 32'd0);
        check("rst_din0", 32'(DataIn0), 32'd0);
        check("rst_ack1", 32'(Ack1), 32'd0);
        check("rst_wr1", 32'(WriteMem1), 32'd0);
      end else begin
        check("ack0", 32'(Ack0), 32'(m_ack));
        check("ack1", 32'(Ack1), 32'(m_ack));
        check("busy0", 32'(Busy0), 32'(m_run));
        check("busy1", 32'(Busy1), 32'(m_run));
        check("rd0", 32'(ReadMem0), 32'(m_run && m_k < 2));
        check("rd1", 32'(ReadMem1), 32'(m_run && m_k < 2));
        check("wr0", 32'(WriteMem0), 32'(m_run && m_k >= m_lat - 2));
        check("wr1", 32'(WriteMem1), 32'(m_run && m_k >= m_lat - 2));
        if (m_run && m_k < 2) begin
          check("rd_addr0", 32'(DataAddress0), 32'(8 + m_k));
          check("rd_addr1", 32'(DataAddress1), 32'(8 + m_k));
        end
        if (m_run && m_k >= m_lat - 2) begin
          check("wr_addr0", 32'(DataAddress0), 32'(10 + m_k - (m_lat - 2)));
          check("wr_addr1", 32'(DataAddress1), 32'(10 + m_k - (m_lat - 2)));
          check("wr_data0", 32'(DataIn0), 32'((m_k == m_lat - 2) ? m_res0[15:8] : m_res0[7:0]));
          check("wr_data1", 32'(DataIn1), 32'((m_k == m_lat - 2) ? m_res1[15:8] : m_res1[7:0]));
        end
      end
    end
  end

  task automatic set_div(input logic [15:0] dv, input logic [7:0] fill_hi, input logic [7:0] fill_lo);
    mem0[8] = dv[15:8];  mem0[9] = dv[7:0];
    mem1[8] = dv[15:8];  mem1[9] = dv[7:0];
    mem0[10] = fill_hi;  mem0[11] = fill_lo;
    mem1[10] = fill_hi;  mem1[11] = fill_lo;
  endtask

  // Starts at the launch edge; counts edges until Ack and write cycles seen.
  task automatic finish_run(input logic [15:0] e0, input logic [15:0] e1, input int elat, input bit toggle);
    int  cnt;
    int  wcnt;
    bit  got;
    cnt = 0; wcnt = 0; got = 1'b0;
    @(posedge Clk);
    while (!got && cnt < 60) begin
      @(posedge Clk);
      #1;
      cnt++;
      if (WriteMem0) wcnt++;
      if (toggle && cnt == 5) Start = 1'b1;
      if (toggle && cnt == 6) Start = 1'b0;
      if (Ack0) got = 1'b1;
    end
    check("latency", 32'(cnt), 32'(elat));
    check("write_cycles", 32'(wcnt), 32'd2);
    check("res0_hi", 32'(mem0[10]), 32'(e0[15:8]));
    check("res0_lo", 32'(mem0[11]), 32'(e0[7:0]));
    check("res1_hi", 32'(mem1[10]), 32'(e1[15:8]));
    check("res1_lo", 32'(mem1[11]), 32'(e1[7:0]));
  endtask

  // Called from DONE: one-cycle Start pulse re-arms, then launch.
  task automatic run(input logic [15:0] dv, input logic [15:0] e0, input logic [15:0] e1,
                     input int elat, input bit toggle);
    set_div(dv, 8'h5A, 8'hA5);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    check("ack_clear0", 32'(Ack0), 32'd0);
    check("busy_idle0", 32'(Busy0), 32'd0);
    #1;
    Start = 1'b0;
    finish_run(e0, e1, elat, toggle);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    set_div(16'd36, 8'h00, 8'h00);
    @(posedge Clk);
    #1;
    check("reset_ack", 32'(Ack0), 32'd0);
    check("reset_addr", 32'(DataAddress0), 32'd0);
    Start = 1'b0;
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    finish_run(16'h038E, 16'h038E, 22, 1'b0);

    run(16'd36,    16'h038E, 16'h038E, 22, 1'b1);
    run(16'd4,     16'h2000, 16'h2000, 22, 1'b0);
    run(16'd1,     16'h8000, 16'h8000, 22, 1'b0);
    run(16'hFFFF,  16'h0000, 16'h0001, 22, 1'b0);
    run(16'd3,     16'h2AAA, 16'h2AAB, 22, 1'b0);
    run(16'h8001,  16'h0000, 16'h0001, 22, 1'b0);
    run(16'd0,     16'hFFFF, 16'hFFFF, 5,  1'b0);

    // Abort in the middle of the divide, then relaunch out of reset.
    set_div(16'd36, 8'h11, 8'h22);
    Start = 1'b1;
    @(posedge Clk);
    #2;
    Start = 1'b0;
    @(posedge Clk);
    repeat (10) @(posedge Clk);
    #2;
    Reset = 1'b1;
    Start = 1'b1;
    #1;
    check("abort_ack0", 32'(Ack0), 32'd0);
    check("abort_wr0", 32'(WriteMem0), 32'd0);
    check("abort_wr1", 32'(WriteMem1), 32'd0);
    check("abort_busy0", 32'(Busy0), 32'd0);
    repeat (2) @(posedge Clk);
    #2;
    check("abort_mem_hi", 32'(mem0[10]), 32'h11);
    check("abort_mem_lo", 32'(mem0[11]), 32'h22);
    Start = 1'b0;
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    finish_run(16'h038E, 16'h038E, 22, 1'b0);

    repeat (3) @(posedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
